// File: rtl/traffic_lights_cfg_sched.sv
// rtl/traffic_lights_cfg_sched.sv - round-robin timing-set loader for one traffic_lights command port
//
// Several requesters share the command port of one traffic_lights controller.
// The round-robin winner has its {green, red, yellow} timing set captured.
// The block then issues the burst MANUAL -> SET_GREEN -> SET_RED -> SET_YELLOW -> ON.
// Each command is valid for one cycle and is followed by GAP_CYCLES idle cycles.
// A rising edge on off_i issues OFF from any state and kills a burst in flight.
// The falling edge of off_i issues ON.
//
// Optional feature macro: TL_CFG_SCHED_ZERO_CLAMP_EN
//   When defined, a captured timing word of 0 is issued as 1.
//
// Ports:
//   clk_i         clock (shared with traffic_lights)
//   arst_i        asynchronous active-high reset
//   req_i         per-requester load request (level, held until gnt_o)
//   cfg_green_i   green time, requester k in [16k+15:16k]
//   cfg_red_i     red time, same slicing
//   cfg_yellow_i  yellow time, same slicing
//   gnt_o         one-hot grant pulse (cfg captured)
//   done_o        pulse with the ON that completes that requester's burst
//   abort_o       pulse when a burst is killed by off_i
//   off_i         emergency off (level)
//   busy_o        state not IDLE_S or gap counter running
//   cmd_type_o    command type to traffic_lights
//   cmd_valid_o   command strobe, one cycle per command
//   cmd_data_o    command data (timing for SET_* commands, else 0)

module traffic_lights_cfg_sched #(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 0
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [16*NUM_REQ-1:0]  cfg_green_i,
  input  logic [16*NUM_REQ-1:0]  cfg_red_i,
  input  logic [16*NUM_REQ-1:0]  cfg_yellow_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic                   abort_o,
  input  logic                   off_i,
  output logic                   busy_o,
  output logic [2:0]             cmd_type_o,
  output logic                   cmd_valid_o,
  output logic [15:0]            cmd_data_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_CYCLES);

  localparam logic [2:0] CMD_ON         = 3'd0;
  localparam logic [2:0] CMD_OFF        = 3'd1;
  localparam logic [2:0] CMD_MANUAL     = 3'd2;
  localparam logic [2:0] CMD_SET_GREEN  = 3'd3;
  localparam logic [2:0] CMD_SET_RED    = 3'd4;
  localparam logic [2:0] CMD_SET_YELLOW = 3'd5;

  // Each burst state names the command issued most recently. The FSM waits
  // in that state while the gap counter drains. ON_S drains the gap after ON.
  typedef enum logic [2:0] {
    IDLE_S, MAN_S, SETG_S, SETR_S, SETY_S, ON_S, OFF_S
  } state_t;

  state_t              state_q, state_n;
  logic [GW-1:0]       gap_q, gap_n;
  logic [PW-1:0]       ptr_q, ptr_n;   // first requester to search next time
  logic [PW-1:0]       cur_q, cur_n;   // owner of the burst in flight
  logic [15:0]         cfg_g_q, cfg_g_n, cfg_r_q, cfg_r_n, cfg_y_q, cfg_y_n;
  logic                off_q;
  logic [NUM_REQ-1:0]  gnt_q, gnt_n, done_q, done_n;
  logic                abort_q, abort_n;
  logic [2:0]          type_q, type_n;
  logic                valid_q, valid_n;
  logic [15:0]         data_q, data_n;

  logic                win_found;
  logic [PW-1:0]       win_idx, cand;
  logic [15:0]         sel_g, sel_r, sel_y;
  logic                off_rise, off_fall;

  assign off_rise = off_i & ~off_q;
  assign off_fall = ~off_i & off_q;

  function automatic logic [15:0] clamp(input logic [15:0] v);
`ifdef TL_CFG_SCHED_ZERO_CLAMP_EN
    // traffic_lights counts to (time - 1), so a zero would wrap around.
    return (v == 16'd0) ? 16'd1 : v;
`else
    return v;
`endif
  endfunction

  // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_g = '0;
    sel_r = '0;
    sel_y = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == PW'(k)) begin
        sel_g = cfg_green_i[16*k +: 16];
        sel_r = cfg_red_i[16*k +: 16];
        sel_y = cfg_yellow_i[16*k +: 16];
      end
    end
  end

  always_comb begin
    state_n = state_q;
    gap_n   = (gap_q != '0) ? gap_q - GW'(1) : '0;
    ptr_n   = ptr_q;
    cur_n   = cur_q;
    cfg_g_n = cfg_g_q;
    cfg_r_n = cfg_r_q;
    cfg_y_n = cfg_y_q;
    gnt_n   = '0;
    done_n  = '0;
    abort_n = 1'b0;
    type_n  = CMD_ON;
    valid_n = 1'b0;
    data_n  = '0;

    if (off_rise) begin
      // Emergency off preempts everything, including a pending gap.
      state_n = OFF_S;
      gap_n   = '0;
      valid_n = 1'b1;
      type_n  = CMD_OFF;
      abort_n = (state_q == MAN_S) || (state_q == SETG_S) ||
                (state_q == SETR_S) || (state_q == SETY_S);
    end else begin
      case (state_q)
        IDLE_S: begin
          if (gap_q == '0 && !off_i && win_found) begin
            gnt_n[win_idx] = 1'b1;
            cur_n   = win_idx;
            ptr_n   = PW'((int'(win_idx) + 1) % NUM_REQ);
            cfg_g_n = clamp(sel_g);
            cfg_r_n = clamp(sel_r);
            cfg_y_n = clamp(sel_y);
            state_n = MAN_S;
            valid_n = 1'b1;
            type_n  = CMD_MANUAL;
            gap_n   = GAP_RELOAD;
          end
        end
        MAN_S: if (gap_q == '0) begin
          state_n = SETG_S;
          valid_n = 1'b1;
          type_n  = CMD_SET_GREEN;
          data_n  = cfg_g_q;
          gap_n   = GAP_RELOAD;
        end
        SETG_S: if (gap_q == '0) begin
          state_n = SETR_S;
          valid_n = 1'b1;
          type_n  = CMD_SET_RED;
          data_n  = cfg_r_q;
          gap_n   = GAP_RELOAD;
        end
        SETR_S: if (gap_q == '0) begin
          state_n = SETY_S;
          valid_n = 1'b1;
          type_n  = CMD_SET_YELLOW;
          data_n  = cfg_y_q;
          gap_n   = GAP_RELOAD;
        end
        SETY_S: if (gap_q == '0) begin
          state_n        = ON_S;
          valid_n        = 1'b1;
          type_n         = CMD_ON;
          done_n[cur_q]  = 1'b1;
          gap_n          = GAP_RELOAD;
        end
        ON_S: if (gap_q == '0) begin
          state_n = IDLE_S;
        end
        OFF_S: if (off_fall) begin
          state_n = IDLE_S;
          valid_n = 1'b1;
          type_n  = CMD_ON;
          gap_n   = GAP_RELOAD;
        end
        default: state_n = IDLE_S;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE_S;
      gap_q   <= '0;
      ptr_q   <= '0;
      cur_q   <= '0;
      cfg_g_q <= '0;
      cfg_r_q <= '0;
      cfg_y_q <= '0;
      off_q   <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      abort_q <= 1'b0;
      type_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_n;
      gap_q   <= gap_n;
      ptr_q   <= ptr_n;
      cur_q   <= cur_n;
      cfg_g_q <= cfg_g_n;
      cfg_r_q <= cfg_r_n;
      cfg_y_q <= cfg_y_n;
      off_q   <= off_i;
      gnt_q   <= gnt_n;
      done_q  <= done_n;
      abort_q <= abort_n;
      type_q  <= type_n;
      valid_q <= valid_n;
      data_q  <= data_n;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign abort_o     = abort_q;
  assign cmd_type_o  = type_q;
  assign cmd_valid_o = valid_q;
  assign cmd_data_o  = data_q;
  assign busy_o      = (state_q != IDLE_S) || (gap_q != '0);

endmodule

// File: tb/tb_traffic_lights_cfg_sched.sv
// tb/tb_traffic_lights_cfg_sched.sv - scoreboard bench for traffic_lights_cfg_sched

module tb_traffic_lights_cfg_sched;

  logic clk = 1'b0;
  logic arst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] cfg_g, cfg_r, cfg_y;

  // dut0: GAP_CYCLES=0, dut1: GAP_CYCLES=2
  logic [1:0]  req0, gnt0, done0;
  logic        off0, abort0, busy0, valid0;
  logic [2:0]  type0;
  logic [15:0] data0;
  logic [1:0]  req1, gnt1, done1;
  logic        off1, abort1, busy1, valid1;
  logic [2:0]  type1;
  logic [15:0] data1;

  traffic_lights_cfg_sched #(.NUM_REQ(2), .GAP_CYCLES(0)) dut0 (
    .clk_i(clk), .arst_i(arst), .req_i(req0),
    .cfg_green_i(cfg_g), .cfg_red_i(cfg_r), .cfg_yellow_i(cfg_y),
    .gnt_o(gnt0), .done_o(done0), .abort_o(abort0), .off_i(off0), .busy_o(busy0),
    .cmd_type_o(type0), .cmd_valid_o(valid0), .cmd_data_o(data0)
  );

  traffic_lights_cfg_sched #(.NUM_REQ(2), .GAP_CYCLES(2)) dut1 (
    .clk_i(clk), .arst_i(arst), .req_i(req1),
    .cfg_green_i(cfg_g), .cfg_red_i(cfg_r), .cfg_yellow_i(cfg_y),
    .gnt_o(gnt1), .done_o(done1), .abort_o(abort1), .off_i(off1), .busy_o(busy1),
    .cmd_type_o(type1), .cmd_valid_o(valid1), .cmd_data_o(data1)
  );

  typedef struct {
    logic [2:0]  t;
    logic [15:0] d;
    int          c;    // expected cycle, -1 = any
    logic [1:0]  g;
    logic [1:0]  dn;
    logic        ab;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   n_chk = 0;
  int   n_fail = 0;

`ifdef TL_CFG_SCHED_ZERO_CLAMP_EN
  localparam logic [15:0] ZERO_G_EXP = 16'd1;
`else
  localparam logic [15:0] ZERO_G_EXP = 16'd0;
`endif

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm, input logic [63:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %h expected nothing (cycle %0d)", nm, act, cyc);
  endtask

  function automatic logic [63:0] pk(input logic [2:0] t, input logic [15:0] d,
                                     input logic [1:0] g, input logic [1:0] dn,
                                     input logic ab, input int c);
    return {8'h00, t, d, g, dn, ab, 32'(c)};
  endfunction

  task automatic push(input int which, input logic [2:0] t, input logic [15:0] d,
                      input int c, input logic [1:0] g, input logic [1:0] dn, input logic ab);
    exp_t e;
    e.t = t; e.d = d; e.c = c; e.g = g; e.dn = dn; e.ab = ab;
    if (which == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Full MANUAL..ON burst for one requester; c0 = MAN cycle or -1.
  task automatic push_burst(input int which, input logic [1:0] g, input logic [15:0] gv,
                            input logic [15:0] rv, input logic [15:0] yv,
                            input int c0, input int step);
    push(which, 3'd2, 16'd0, c0,                         g,    2'b00, 1'b0);
    push(which, 3'd3, gv,    (c0 < 0) ? -1 : c0 + step,   2'b00, 2'b00, 1'b0);
    push(which, 3'd4, rv,    (c0 < 0) ? -1 : c0 + 2*step, 2'b00, 2'b00, 1'b0);
    push(which, 3'd5, yv,    (c0 < 0) ? -1 : c0 + 3*step, 2'b00, 2'b00, 1'b0);
    push(which, 3'd0, 16'd0, (c0 < 0) ? -1 : c0 + 4*step, 2'b00, g,     1'b0);
  endtask

  always @(negedge clk) begin
    if (!arst) begin
      if (valid0) begin
        if (q0.size() == 0) fail_now("dut0 unexpected command", pk(type0, data0, gnt0, done0, abort0, cyc));
        else begin
          e0 = q0.pop_front();
          check("dut0 command", pk(type0, data0, gnt0, done0, abort0, (e0.c < 0) ? 0 : cyc),
                pk(e0.t, e0.d, e0.g, e0.dn, e0.ab, (e0.c < 0) ? 0 : e0.c));
        end
      end else if (gnt0 != 2'b00 || done0 != 2'b00 || abort0)
        fail_now("dut0 strobe without command", {59'd0, gnt0, done0, abort0});
      if (valid1) begin
        if (q1.size() == 0) fail_now("dut1 unexpected command", pk(type1, data1, gnt1, done1, abort1, cyc));
        else begin
          e1 = q1.pop_front();
          check("dut1 command", pk(type1, data1, gnt1, done1, abort1, (e1.c < 0) ? 0 : cyc),
                pk(e1.t, e1.d, e1.g, e1.dn, e1.ab, (e1.c < 0) ? 0 : e1.c));
        end
      end else if (gnt1 != 2'b00 || done1 != 2'b00 || abort1)
        fail_now("dut1 strobe without command", {59'd0, gnt1, done1, abort1});
    end
  end

  task automatic wait_idle(input int which);
    int n = 0;
    while (((which == 0) ? busy0 : busy1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check((which == 0) ? "dut0 idle" : "dut1 idle", {63'd0, (which == 0) ? busy0 : busy1}, 64'd0);
    check((which == 0) ? "dut0 queue drained" : "dut1 queue drained",
          64'((which == 0) ? q0.size() : q1.size()), 64'd0);
  endtask

  int c;
  int gcount;
  int n;

  initial begin
    arst  = 1'b1;
    req0  = 2'b00; off0 = 1'b0;
    req1  = 2'b00; off1 = 1'b0;
    cfg_g = {16'h0100, 16'd5};
    cfg_r = {16'h0200, 16'd6};
    cfg_y = {16'h0300, 16'd7};
    repeat (3) @(negedge clk);
    check("reset dut0 outputs", {38'd0, gnt0, done0, abort0, busy0, type0, valid0, data0}, 64'd0);
    check("reset dut1 outputs", {38'd0, gnt1, done1, abort1, busy1, type1, valid1, data1}, 64'd0);
    arst = 1'b0;
    @(negedge clk);

    // single request, back-to-back commands
    c = cyc;
    req0 = 2'b01;
    push_burst(0, 2'b01, 16'd5, 16'd6, 16'd7, c + 1, 1);
    @(negedge clk);
    req0 = 2'b00;
    wait_idle(0);

    // same request with GAP_CYCLES=2
    c = cyc;
    req1 = 2'b01;
    push_burst(1, 2'b01, 16'd5, 16'd6, 16'd7, c + 1, 3);
    @(negedge clk);
    req1 = 2'b00;
    wait_idle(1);

    @(negedge clk); arst = 1'b1;
    @(negedge clk); arst = 1'b0;
    @(negedge clk);

    // both requesting: grants 0,1,0,1, each burst complete before the next
    req0 = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_burst(0, 2'b01, 16'd5, 16'd6, 16'd7, -1, 1);
      else push_burst(0, 2'b10, 16'h0100, 16'h0200, 16'h0300, -1, 1);
    end
    gcount = 0;
    n = 0;
    while (gcount < 4 && n < 400) begin
      @(negedge clk);
      n++;
      if (gnt0 != 2'b00) gcount++;
    end
    req0 = 2'b00;
    check("four grants seen", 64'(gcount), 64'd4);
    wait_idle(0);

    // off_i kills requester 1's burst, then requester 0 is served first
    c = cyc;
    req0 = 2'b10;
    push(0, 3'd2, 16'd0,     c + 1, 2'b10, 2'b00, 1'b0);
    push(0, 3'd3, 16'h0100,  c + 2, 2'b00, 2'b00, 1'b0);
    push(0, 3'd1, 16'd0,     c + 3, 2'b00, 2'b00, 1'b1);
    @(negedge clk); req0 = 2'b00;
    @(negedge clk); off0 = 1'b1;
    repeat (3) @(negedge clk);
    req0 = 2'b11;
    repeat (7) @(negedge clk);
    off0 = 1'b0;
    push(0, 3'd0, 16'd0, c + 13, 2'b00, 2'b00, 1'b0);
    push_burst(0, 2'b01, 16'd5, 16'd6, 16'd7, c + 14, 1);
    @(negedge clk);
    @(negedge clk);
    req0 = 2'b00;
    wait_idle(0);

    // off_i and req_i rise together; zero green; cfg changed after grant
    cfg_g[15:0] = 16'd0;
    c = cyc;
    req0 = 2'b01;
    off0 = 1'b1;
    push(0, 3'd1, 16'd0, c + 1, 2'b00, 2'b00, 1'b0);
    repeat (5) @(negedge clk);
    off0 = 1'b0;
    push(0, 3'd0, 16'd0, c + 6, 2'b00, 2'b00, 1'b0);
    push_burst(0, 2'b01, ZERO_G_EXP, 16'd6, 16'd7, c + 7, 1);
    @(negedge clk);
    @(negedge clk);
    req0 = 2'b00;
    cfg_g[15:0] = 16'd5;
    wait_idle(0);

    // asynchronous reset in the middle of a burst
    c = cyc;
    req0 = 2'b01;
    push(0, 3'd2, 16'd0, c + 1, 2'b01, 2'b00, 1'b0);
    push(0, 3'd3, 16'd5, c + 2, 2'b00, 2'b00, 1'b0);
    @(negedge clk); req0 = 2'b00;
    @(negedge clk);
    #2 arst = 1'b1;
    #1 check("async reset outputs", {38'd0, gnt0, done0, abort0, busy0, type0, valid0, data0}, 64'd0);
    @(posedge clk);
    #2 arst = 1'b0;
    repeat (8) @(negedge clk);
    check("dut0 no burst after reset", {63'd0, busy0}, 64'd0);
    check("dut0 final queue", 64'(q0.size()), 64'd0);
    check("dut1 final queue", 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
